// File: rtl/shooter.sv
// Projectile launcher: takes a fire request with an aim vector, moves the ball
// once per frame tick, and retires it on insertion or when it leaves the screen.
module shooter #(
  parameter int SHOOTER_X = 320,
  parameter int SHOOTER_Y = 400,
  parameter int PARK_X    = 50,
  parameter int PARK_Y    = 50,
  parameter int SCREEN_W  = 640,
  parameter int SCREEN_H  = 480
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       fire,
  input  logic [4:0] aim_dx,
  input  logic [4:0] aim_dy,
  input  logic       inserted,
  input  logic [1:0] Game_State,
  output logic [9:0] Shooted_pos_X,
  output logic [9:0] Shooted_pos_Y,
  output logic [3:0] Color_in,
  output logic [3:0] Loaded_color,
  output logic [3:0] Next_color,
  output logic       busy,
  output logic [7:0] shots,
  output logic [7:0] misses
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FLIGHT = 2'd1,
    RETIRE = 2'd2
  } state_t;

  localparam logic [1:0]  PLAYING  = 2'b01;
  localparam logic [9:0]  ORIGIN_X = 10'(SHOOTER_X);
  localparam logic [9:0]  ORIGIN_Y = 10'(SHOOTER_Y);
  localparam logic [9:0]  PARKED_X = 10'(PARK_X);
  localparam logic [9:0]  PARKED_Y = 10'(PARK_Y);
  localparam logic [10:0] LIMIT_X  = 11'(SCREEN_W);
  localparam logic [10:0] LIMIT_Y  = 11'(SCREEN_H);
  localparam logic [7:0]  LFSR_SEED = 8'h4A;

  // Observable for checkers through hierarchy.
  state_t     state;

  logic [7:0] lfsr;
  logic [4:0] dx_q;
  logic [4:0] dy_q;

  logic       frame_meta;
  logic       frame_sync;
  logic       frame_prev;
  logic       tick;

  logic [7:0]  lfsr_nxt;
  logic [10:0] nx;
  logic [10:0] ny;
  logic        out_x;
  logic        out_y;
  logic        fire_ok;

  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  function automatic logic [3:0] colour_of(input logic [7:0] v);
    return {2'b00, v[1:0]} + 4'd1;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  // Next position as 11-bit two's complement; a negative result sets bit 10.
  always_comb begin
    tick     = frame_sync & ~frame_prev;
    lfsr_nxt = lfsr_step(lfsr);
    nx       = {1'b0, Shooted_pos_X} + {{6{dx_q[4]}}, dx_q};
    ny       = {1'b0, Shooted_pos_Y} + {{6{dy_q[4]}}, dy_q};
    out_x    = nx[10] || (nx >= LIMIT_X);
    out_y    = ny[10] || (ny >= LIMIT_Y);
    fire_ok  = (state == IDLE) && (Game_State == PLAYING) && fire &&
               ((aim_dx != 5'd0) || (aim_dy != 5'd0));
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state         <= IDLE;
      Shooted_pos_X <= PARKED_X;
      Shooted_pos_Y <= PARKED_Y;
      Color_in      <= 4'd0;
      busy          <= 1'b0;
      shots         <= 8'd0;
      misses        <= 8'd0;
      lfsr          <= LFSR_SEED;
      Loaded_color  <= 4'd2;
      Next_color    <= 4'd3;
      dx_q          <= 5'd0;
      dy_q          <= 5'd0;
      frame_meta    <= 1'b0;
      frame_sync    <= 1'b0;
      frame_prev    <= 1'b0;
    end else begin
      frame_meta <= frame_clk;
      frame_sync <= frame_meta;
      frame_prev <= frame_sync;

      if (Game_State != PLAYING) begin
        state         <= IDLE;
        Shooted_pos_X <= PARKED_X;
        Shooted_pos_Y <= PARKED_Y;
        Color_in      <= 4'd0;
        busy          <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (fire_ok) begin
              dx_q          <= aim_dx;
              dy_q          <= aim_dy;
              Shooted_pos_X <= ORIGIN_X;
              Shooted_pos_Y <= ORIGIN_Y;
              Color_in      <= Loaded_color;
              Loaded_color  <= Next_color;
              lfsr          <= lfsr_nxt;
              Next_color    <= colour_of(lfsr_nxt);
              shots         <= sat_inc(shots);
              busy          <= 1'b1;
              state         <= FLIGHT;
            end
          end
          FLIGHT: begin
            // Insertion wins over an off-screen step on the same cycle.
            if (inserted) begin
              Shooted_pos_X <= PARKED_X;
              Shooted_pos_Y <= PARKED_Y;
              Color_in      <= 4'd0;
              state         <= RETIRE;
            end else if (tick) begin
              if (out_x || out_y) begin
                Shooted_pos_X <= PARKED_X;
                Shooted_pos_Y <= PARKED_Y;
                Color_in      <= 4'd0;
                misses        <= sat_inc(misses);
                state         <= RETIRE;
              end else begin
                Shooted_pos_X <= nx[9:0];
                Shooted_pos_Y <= ny[9:0];
              end
            end
          end
          RETIRE: begin
            // Hold one frame parked so path sees the ball gone before relaunch.
            if (tick) begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_shooter.sv
// Directed bench for shooter: launch, flight, retirement paths, colour queue
// and counters, with hand-computed expectations.
module tb_shooter;

  logic       clk;
  logic       rst_n;
  logic       frame_clk;
  logic       fire;
  logic [4:0] aim_dx;
  logic [4:0] aim_dy;
  logic       inserted;
  logic [1:0] game_state;
  logic [9:0] pos_x;
  logic [9:0] pos_y;
  logic [3:0] color_in;
  logic [3:0] loaded_color;
  logic [3:0] next_color;
  logic       busy;
  logic [7:0] shots;
  logic [7:0] misses;

  int vectors;
  int miscompares;

  shooter dut (
    .Clk          (clk),
    .Reset        (rst_n),
    .frame_clk    (frame_clk),
    .fire         (fire),
    .aim_dx       (aim_dx),
    .aim_dy       (aim_dy),
    .inserted     (inserted),
    .Game_State   (game_state),
    .Shooted_pos_X(pos_x),
    .Shooted_pos_Y(pos_y),
    .Color_in     (color_in),
    .Loaded_color (loaded_color),
    .Next_color   (next_color),
    .busy         (busy),
    .shots        (shots),
    .misses       (misses)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_pos(input string tag, input int x, input int y);
    check({tag, "_x"}, {22'd0, pos_x}, 32'(x));
    check({tag, "_y"}, {22'd0, pos_y}, 32'(y));
  endtask

  // One full frame strobe; the tick lands inside it and the sync chain settles low.
  task automatic frame_strobe();
    @(negedge clk) frame_clk = 1'b1;
    repeat (4) @(negedge clk);
    frame_clk = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic pulse_fire(input logic [4:0] dx, input logic [4:0] dy);
    @(negedge clk);
    aim_dx = dx;
    aim_dy = dy;
    fire   = 1'b1;
    @(negedge clk);
    fire   = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    frame_clk   = 1'b0;
    fire        = 1'b0;
    aim_dx      = 5'd0;
    aim_dy      = 5'd0;
    inserted    = 1'b0;
    game_state  = 2'b01;

    // Reset state
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_pos("rst_pos", 50, 50);
    check("rst_color", 32'(color_in), 32'd0);
    check("rst_loaded", 32'(loaded_color), 32'd2);
    check("rst_next", 32'(next_color), 32'd3);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_shots", 32'(shots), 32'd0);
    check("rst_misses", 32'(misses), 32'd0);

    // Shot 1: aim (0,-4); fire held for several cycles must not re-launch
    aim_dx = 5'd0;
    aim_dy = 5'b11100;
    fire   = 1'b1;
    @(negedge clk);
    check("s1_color", 32'(color_in), 32'd2);
    check_pos("s1_launch", 320, 400);
    check("s1_loaded", 32'(loaded_color), 32'd3);
    check("s1_next", 32'(next_color), 32'd2);
    check("s1_shots", 32'(shots), 32'd1);
    check("s1_busy", 32'(busy), 32'd1);
    repeat (3) @(negedge clk);
    fire = 1'b0;
    check("s1_held_shots", 32'(shots), 32'd1);

    repeat (3) frame_strobe();
    check_pos("s1_3ticks", 320, 388);
    repeat (97) frame_strobe();
    check_pos("s1_y0", 320, 0);
    check("s1_y0_misses", 32'(misses), 32'd0);
    frame_strobe();
    check_pos("s1_off", 50, 50);
    check("s1_off_color", 32'(color_in), 32'd0);
    check("s1_off_misses", 32'(misses), 32'd1);
    check("s1_off_busy", 32'(busy), 32'd1);
    frame_strobe();
    check("s1_idle_busy", 32'(busy), 32'd0);

    // Shot 2: aim (0,-4); tick latency measured edge by edge
    pulse_fire(5'd0, 5'b11100);
    check("s2_shots", 32'(shots), 32'd2);
    check("s2_color", 32'(color_in), 32'd3);
    check("s2_loaded", 32'(loaded_color), 32'd2);
    check("s2_next", 32'(next_color), 32'd3);
    frame_clk = 1'b1;
    @(negedge clk);
    check("s2_edge1_y", 32'(pos_y), 32'd400);
    @(negedge clk);
    check("s2_edge2_y", 32'(pos_y), 32'd400);
    @(negedge clk);
    check("s2_edge3_y", 32'(pos_y), 32'd396);
    @(negedge clk);
    frame_clk = 1'b0;
    repeat (3) @(negedge clk);
    check("s2_one_tick_y", 32'(pos_y), 32'd396);
    frame_strobe();
    check_pos("s2_mid", 320, 392);

    // Insertion mid-flight: park next Clk, no miss
    inserted = 1'b1;
    @(negedge clk);
    inserted = 1'b0;
    check_pos("s2_ins", 50, 50);
    check("s2_ins_color", 32'(color_in), 32'd0);
    check("s2_ins_misses", 32'(misses), 32'd1);
    check("s2_ins_busy", 32'(busy), 32'd1);

    // Fire during RETIRE is ignored
    pulse_fire(5'd3, 5'd0);
    check("retire_fire_shots", 32'(shots), 32'd2);
    check("retire_fire_color", 32'(color_in), 32'd0);
    frame_strobe();
    check("s2_idle_busy", 32'(busy), 32'd0);

    // Zero aim does not launch; inserted in IDLE has no effect
    inserted = 1'b1;
    pulse_fire(5'd0, 5'd0);
    inserted = 1'b0;
    check("zero_aim_shots", 32'(shots), 32'd2);
    check("zero_aim_busy", 32'(busy), 32'd0);
    check("zero_aim_misses", 32'(misses), 32'd1);

    // Shot 3: aim (+15,-16); leave play mid-flight
    pulse_fire(5'b01111, 5'b10000);
    check("s3_color", 32'(color_in), 32'd2);
    check("s3_loaded", 32'(loaded_color), 32'd3);
    check("s3_next", 32'(next_color), 32'd1);
    check("s3_shots", 32'(shots), 32'd3);
    frame_strobe();
    check_pos("s3_tick", 335, 384);
    @(negedge clk) game_state = 2'b00;
    @(negedge clk);
    check_pos("gs_park", 50, 50);
    check("gs_color", 32'(color_in), 32'd0);
    check("gs_busy", 32'(busy), 32'd0);
    check("gs_shots", 32'(shots), 32'd3);
    check("gs_loaded", 32'(loaded_color), 32'd3);
    pulse_fire(5'd1, 5'd1);
    check("gs_fire_shots", 32'(shots), 32'd3);
    check("gs_fire_busy", 32'(busy), 32'd0);
    game_state = 2'b01;

    // Shot 4: aim (-16,+5); asynchronous reset mid-flight
    pulse_fire(5'b10000, 5'b00101);
    check("s4_color", 32'(color_in), 32'd3);
    check("s4_loaded", 32'(loaded_color), 32'd1);
    check("s4_next", 32'(next_color), 32'd2);
    check("s4_shots", 32'(shots), 32'd4);
    frame_strobe();
    check_pos("s4_tick", 304, 405);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_pos("midrst", 50, 50);
    check("midrst_shots", 32'(shots), 32'd0);
    check("midrst_misses", 32'(misses), 32'd0);
    check("midrst_color", 32'(color_in), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_loaded", 32'(loaded_color), 32'd2);
    check("midrst_next", 32'(next_color), 32'd3);
    @(negedge clk);
    rst_n = 1'b1;

    // Shot 5: aim (-16,0) runs to X=0, then exits left
    pulse_fire(5'b10000, 5'd0);
    check("s5_color", 32'(color_in), 32'd2);
    check("s5_shots", 32'(shots), 32'd1);
    repeat (20) frame_strobe();
    check_pos("s5_x0", 0, 400);
    frame_strobe();
    check_pos("s5_off", 50, 50);
    check("s5_misses", 32'(misses), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/shooter.md
Name: shooter

Overview:
- Projectile launcher feeding the path block.
- Accepts a fire request with an aim vector and launches the loaded ball from the shooter origin.
- Advances the ball once per frame tick and drives Shooted_pos_X/Y and Color_in to path.
- Retires the ball when path reports an insertion or the ball leaves the screen. Keeps a two-deep colour queue (loaded/next) fed by an LFSR.

Parameters:
SHOOTER_X, 320, launch origin X (pixels)
SHOOTER_Y, 400, launch origin Y (pixels)
PARK_X, 50, parked X driven when no ball is in flight
PARK_Y, 50, parked Y driven when no ball is in flight
SCREEN_W, 640, X bound (valid X 0..SCREEN_W-1)
SCREEN_H, 480, Y bound (valid Y 0..SCREEN_H-1)

Ports:
Clk  in  1  system clock
Reset  in  1  asynchronous, active-low reset
frame_clk  in  1  frame strobe, asynchronous to Clk
fire  in  1  level; launch request
aim_dx  in  5  signed per-frame X step, -16..+15
aim_dy  in  5  signed per-frame Y step, -16..+15
inserted  in  1  from path; in-flight ball has been absorbed
Game_State  in  2  2'b01 = playing; any other value = not playing
Shooted_pos_X  out  10  projectile X to path
Shooted_pos_Y  out  10  projectile Y to path
Color_in  out  4  in-flight ball colour to path, 0 = none
Loaded_color  out  4  colour that the next shot will use
Next_color  out  4  colour queued behind Loaded_color
busy  out  1  high in FLIGHT and RETIRE
shots  out  8  accepted fires, saturates at 255
misses  out  8  off-screen retirements, saturates at 255

Behaviour:
- Reset (Reset=0, asynchronous) sets all outputs and state:
  - state=IDLE; Shooted_pos=(PARK_X,PARK_Y); Color_in=0; busy=0; shots=0; misses=0.
  - lfsr=8'h4A; Loaded_color=2; Next_color=3.
  - Frame synchroniser flops cleared.
- Reset is honoured mid-flight: ball vanishes and counters clear.
- Frame tick:
  - frame_clk passes through a 2-flop synchroniser, then a rising-edge detector.
  - tick is a 1-Clk pulse.
  - Position updates on the Clk edge where tick=1, i.e. the third Clk edge after frame_clk is first sampled high.
- LFSR step: 8-bit Fibonacci, shift left, new bit0 = l[7]^l[5]^l[4]^l[3]. Colour from a value v = v[1:0]+1, range 1..4.
- Fire is accepted when all hold: state=IDLE, Game_State=01, fire=1, {aim_dx,aim_dy} not both zero.
- On acceptance, in one cycle:
  - Latch aim; Shooted_pos=(SHOOTER_X,SHOOTER_Y); Color_in=Loaded_color.
  - Loaded_color<=Next_color; lfsr<=step(lfsr); Next_color<=colour(step(lfsr)).
  - shots++ (saturating); state<=FLIGHT.
- fire held high causes no repeat until the state returns to IDLE. Fire while busy is ignored.
- FLIGHT:
  - On each tick, compute X+dx and Y+dy in 11-bit signed. If the result is in bounds, register it.
  - If out of bounds (<0 or >= SCREEN_W/SCREEN_H): Shooted_pos=PARK, Color_in=0, misses++, state<=RETIRE. The out-of-range value is never driven.
  - inserted=1 on any Clk in FLIGHT: Shooted_pos=PARK, Color_in=0, state<=RETIRE; no miss counted.
  - inserted and out-of-bounds on the same tick counts as a hit; misses is unchanged.
- RETIRE: busy=1; on next tick -> IDLE. This guarantees path sees at least one frame with the parked position before the next launch.
- Fire accepted on the same cycle as a tick in IDLE: first motion occurs on the following tick.
- Game_State != 01 in any state: next Clk forces IDLE, Shooted_pos=PARK, Color_in=0, busy=0. Counters and colour queue are held.
- inserted outside FLIGHT is ignored.

Test Plan:
- Reset low then high -> Shooted_pos=(50,50), Color_in=0, Loaded=2, Next=3, busy=0, shots=0.
- Game_State=01, aim=(0,-4), pulse fire -> Color_in=2, pos=(320,400), Loaded=3, Next=2, shots=1. After 3 frame strobes pos=(320,388).
- Continue aim (0,-4) with no inserted -> 100 ticks reach Y=0. Next tick parks at (50,50), misses=1, busy drops after one further tick.
- Mid-flight at pos (320,392), assert inserted for 1 Clk -> pos=(50,50) next Clk, Color_in=0, misses unchanged. Fire during RETIRE ignored; fire after -> shots=2, Color_in=3.
- Fire with aim=(0,0) -> no launch, shots unchanged. Game_State=00 mid-flight -> IDLE and park within 1 Clk. Reset asserted mid-flight -> immediate park, counters 0.
